// File: rtl/audio_direction.sv
// -----------------------------------------------------------------------------
// audio_direction
//
// Compares the summed absolute amplitude of a left and a right microphone
// over a fixed window of samples and reports which side is louder together
// with a scaled, saturated correction magnitude. A steering loop uses
// audio_dir/audio_val to trim a pulse width toward the louder source.
//
// Processing per window:
//   ACCUM   : add |left_in| / |right_in| on every ready strobe
//   COMPARE : register |sum_l - sum_r|, direction and combined energy
//   SCALE   : shift/saturate the difference, qualify against deadband/silence
//   EMIT    : publish the result with a one-cycle audio_done strobe
//
// Ports:
//   clock       system clock, rising-edge active
//   reset       asynchronous active-low reset
//   enable      1 = measure, 0 = idle and discard the current window
//   ready       one-cycle strobe: left_in/right_in hold a new sample pair
//   left_in     signed 8-bit left sample
//   right_in    signed 8-bit right sample
//   audio_dir   1 = left louder, 0 = right louder (registered)
//   audio_val   correction magnitude (registered)
//   audio_done  one-cycle strobe, audio_dir/audio_val valid in the same cycle
// -----------------------------------------------------------------------------
module audio_direction #(
    parameter int WINDOW   = 1024,
    parameter int SHIFT    = 6,
    parameter int DEADBAND = 1024,
    parameter int SILENCE  = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       ready,
    input  logic [7:0] left_in,
    input  logic [7:0] right_in,
    output logic       audio_dir,
    output logic [7:0] audio_val,
    output logic       audio_done
);

    localparam int                CNT_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(WINDOW - 1);
    localparam logic [31:0]       DEADBAND_U = 32'(DEADBAND);
    localparam logic [31:0]       SILENCE_U  = 32'(SILENCE);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        COMPARE,
        SCALE,
        EMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [17:0]      sum_l;
    logic [17:0]      sum_r;
    logic [CNT_W-1:0] sample_cnt;

    logic [17:0]      diff;
    logic             dir_next;
    logic [18:0]      total;

    logic [7:0]       val_next;
    logic             qual;

    logic [17:0]      diff_shifted;
    logic             take_sample;
    logic             last_sample;

    // Magnitude of a two's-complement byte as an unsigned byte; -128 maps to
    // 128 because the result is read as unsigned, so nothing wraps.
    function automatic logic [7:0] mag8(input logic [7:0] s);
        return s[7] ? (~s + 8'd1) : s;
    endfunction

    assign take_sample  = (state == ACCUM) && enable && ready;
    assign last_sample  = take_sample && (sample_cnt == LAST_CNT);
    assign diff_shifted = diff >> SHIFT;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the values present before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)      state_next = ACCUM;
            ACCUM:   if (last_sample) state_next = COMPARE;
            COMPARE:                  state_next = SCALE;
            SCALE:                    state_next = EMIT;
            EMIT:                     state_next = ACCUM;
            default:                  state_next = IDLE;
        endcase
        // Dropping enable abandons whatever is in flight, including an EMIT.
        if (!enable) begin
            state_next = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Window accumulators
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_l      <= '0;
            sum_r      <= '0;
            sample_cnt <= '0;
        end else if (take_sample) begin
            sum_l      <= sum_l + 18'(mag8(left_in));
            sum_r      <= sum_r + 18'(mag8(right_in));
            sample_cnt <= sample_cnt + CNT_W'(1);
        end else if (state == IDLE || state == EMIT || !enable) begin
            sum_l      <= '0;
            sum_r      <= '0;
            sample_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // COMPARE and SCALE pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            diff     <= '0;
            dir_next <= 1'b0;
            total    <= '0;
            val_next <= '0;
            qual     <= 1'b0;
        end else begin
            if (state == COMPARE) begin
                // Equal sums fall into the else branch: diff 0, direction right.
                if (sum_l > sum_r) begin
                    diff     <= sum_l - sum_r;
                    dir_next <= 1'b1;
                end else begin
                    diff     <= sum_r - sum_l;
                    dir_next <= 1'b0;
                end
                total <= {1'b0, sum_l} + {1'b0, sum_r};
            end
            if (state == SCALE) begin
                val_next <= (diff_shifted > 18'd255) ? 8'hFF : diff_shifted[7:0];
                qual     <= (32'(diff) >= DEADBAND_U) && (32'(total) >= SILENCE_U);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: only a qualified, still-enabled EMIT changes them, so the last
    // published result survives IDLE and suppressed windows.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            audio_dir  <= 1'b0;
            audio_val  <= '0;
            audio_done <= 1'b0;
        end else if (state == EMIT && enable && qual) begin
            audio_dir  <= dir_next;
            audio_val  <= val_next;
            audio_done <= 1'b1;
        end else begin
            audio_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_direction.sv
// -----------------------------------------------------------------------------
// tb_audio_direction
//
// Drives windows of sample pairs into audio_direction and predicts each
// published result from window sums computed with plain integer arithmetic.
// Predictions go into a scoreboard queue; a negedge monitor pops one entry
// for every audio_done it sees and compares direction, magnitude and the
// edge on which the strobe appeared.
// -----------------------------------------------------------------------------
module tb_audio_direction;

    localparam int WINDOW   = 1024;
    localparam int SHIFT    = 6;
    localparam int DEADBAND = 1024;
    localparam int SILENCE  = 4096;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       ready;
    logic [7:0] left_in;
    logic [7:0] right_in;
    logic       audio_dir;
    logic [7:0] audio_val;
    logic       audio_done;

    audio_direction #(
        .WINDOW  (WINDOW),
        .SHIFT   (SHIFT),
        .DEADBAND(DEADBAND),
        .SILENCE (SILENCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .ready     (ready),
        .left_in   (left_in),
        .right_in  (right_in),
        .audio_dir (audio_dir),
        .audio_val (audio_val),
        .audio_done(audio_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          dir;
        bit [7:0]    val;
        longint      cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference state: running window sums and last published result.
    int m_sl  = 0;
    int m_sr  = 0;
    int m_cnt = 0;
    bit m_dir = 1'b0;
    int m_val = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int absv(input logic signed [7:0] s);
        int v;
        v = int'(s);
        return (v < 0) ? -v : v;
    endfunction

    // One clock edge with the given inputs presented; returns 1 time unit
    // after the edge so outputs are settled and inputs change away from it.
    task automatic drive_edge(input bit rdy, input logic [7:0] l, input logic [7:0] r);
        ready    = rdy;
        left_in  = l;
        right_in = r;
        @(posedge clock);
        #1;
        ready = 1'b0;
    endtask

    task automatic junk_edge();
        drive_edge(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    task automatic send_sample(input logic signed [7:0] l, input logic signed [7:0] r);
        repeat ($urandom_range(0, 1)) drive_edge(1'b0, 8'($urandom), 8'($urandom));
        drive_edge(1'b1, l, r);
        m_sl  += absv(l);
        m_sr  += absv(r);
        m_cnt++;
    endtask

    task automatic check_held(input string tag);
        check({tag, " audio_dir held"}, audio_dir, m_dir);
        check({tag, " audio_val held"}, audio_val, m_val);
    endtask

    // Sends a full window. kill: 0 none, 1..3 drop enable before the 1st..3rd
    // edge after the final sample, 4 pulse reset over the edge entering EMIT.
    task automatic send_window(input int lf, input int rf, input bit rnd, input int kill);
        logic signed [7:0] l;
        logic signed [7:0] r;
        int     kl;
        int     kr;
        int     diff;
        int     total;
        int     val;
        bit     dir;
        longint e0;
        exp_t   e;
        kl = $urandom_range(0, 3);
        kr = $urandom_range(0, 3);
        for (int i = 0; i < WINDOW; i++) begin
            if (rnd) begin
                l = 8'($urandom);
                r = 8'($urandom);
                l = l >>> kl;
                r = r >>> kr;
            end else begin
                l = 8'(lf);
                r = 8'(rf);
            end
            send_sample(l, r);
        end
        e0    = cyc;
        dir   = (m_sl > m_sr);
        diff  = dir ? (m_sl - m_sr) : (m_sr - m_sl);
        total = m_sl + m_sr;
        val   = diff / (1 << SHIFT);
        if (val > 255) val = 255;
        if (kill == 0 && diff >= DEADBAND && total >= SILENCE) begin
            e.dir = dir;
            e.val = 8'(val);
            e.cyc = e0 + 3;
            sb.push_back(e);
            m_dir = dir;
            m_val = val;
        end
        m_sl  = 0;
        m_sr  = 0;
        m_cnt = 0;
        // Ready strobes during the three result-processing edges are dropped.
        for (int k = 1; k <= 3; k++) begin
            if (kill == 4 && k == 2) begin
                reset = 1'b0;
                #1;
                check("reset audio_done", audio_done, 0);
                check("reset audio_dir", audio_dir, 0);
                check("reset audio_val", audio_val, 0);
                m_dir = 1'b0;
                m_val = 0;
            end
            if (kill == 4 && k == 3) reset = 1'b1;
            if (kill >= 1 && kill <= 3 && k >= kill) enable = 1'b0;
            junk_edge();
        end
        if (kill >= 1 && kill <= 3) begin
            enable = 1'b1;
            junk_edge();
        end
        check_held("window");
    endtask

    // Starts a window, abandons it by dropping enable, and re-arms.
    task automatic partial(input int n);
        for (int i = 0; i < n; i++) begin
            send_sample(8'($urandom), 8'($urandom));
        end
        enable = 1'b0;
        repeat (3) junk_edge();
        m_sl  = 0;
        m_sr  = 0;
        m_cnt = 0;
        enable = 1'b1;
        junk_edge();
        check_held("partial");
    endtask

    // Monitor: every strobe must match the oldest pending prediction.
    always @(negedge clock) begin
        if (reset && audio_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected audio_done: got dir %0d val %0d, none expected (cycle %0d)",
                         audio_dir, audio_val, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done audio_dir", audio_dir, e.dir);
                check("done audio_val", audio_val, e.val);
                check("done timing", cyc, e.cyc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        ready    = 1'b0;
        left_in  = '0;
        right_in = '0;
        #3;
        check("por audio_done", audio_done, 0);
        check("por audio_dir", audio_dir, 0);
        check("por audio_val", audio_val, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        // Ready strobes while idle are ignored.
        repeat (4) junk_edge();
        enable = 1'b1;
        junk_edge();

        send_window(40, 32, 0, 0);     // dir 1, val 128
        send_window(-128, 0, 0, 0);    // dir 1, val 255 (saturated)
        send_window(0, 20, 0, 0);      // dir 0, val 255
        send_window(33, 32, 0, 0);     // on the deadband, val 16
        send_window(32, 32, 0, 0);     // equal: suppressed
        send_window(2, 1, 0, 0);       // below silence: suppressed
        partial(500);
        send_window(-12, 10, 0, 0);    // dir 1, val 32
        for (int k = 1; k <= 3; k++) begin
            send_window(-90, 5, 0, k); // enable drop kills the result
        end
        send_window(40, 32, 0, 4);     // reset before EMIT
        send_window(3, 9, 0, 0);       // dir 0, val 96
        repeat (4) send_window(0, 0, 1, 0);

        repeat (10) junk_edge();
        check("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
